// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    // Measurement FSM states; the divider runs beside MEASURE with its own busy flag.
    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } state_e;

    localparam int unsigned DUTY_BITS = 7;
    localparam logic [DUTY_BITS-1:0] DUTY_SCALE = 7'd100;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// Requires num_i < den_i * 2^QUO_W so the quotient fits in QUO_W bits.
module serial_divider
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_W = 23,
    parameter int unsigned DEN_W = 16,
    parameter int unsigned QUO_W = DUTY_BITS
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [QUO_W-1:0] quo_o
);

    localparam int unsigned StepW = $clog2(QUO_W);
    localparam logic [StepW-1:0] LastStep = StepW'(QUO_W - 1);

    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [QUO_W-1:0] nlo_q;
    logic [QUO_W-1:0] quo_q;
    logic [StepW-1:0] step_q;
    logic             busy_q;
    logic             done_q;

    logic [DEN_W-1:0] rem_src;
    logic [DEN_W-1:0] den_src;
    logic [DEN_W-1:0] rem_sub;
    logic [DEN_W-1:0] rem_nxt;
    logic [DEN_W:0]   rem_sh;
    logic             bit_src;
    logic             q_bit;

    // One restoring step; the first step runs on the start cycle straight from the inputs.
    always_comb begin
        rem_src = busy_q ? rem_q : num_i[QUO_W +: DEN_W];
        bit_src = busy_q ? nlo_q[QUO_W-1] : num_i[QUO_W-1];
        den_src = busy_q ? den_q : den_i;
        rem_sh  = {rem_src, bit_src};
        q_bit   = (rem_sh >= {1'b0, den_src});
        // Difference is below den_src when taken, so the low bits are exact.
        rem_sub = rem_sh[DEN_W-1:0] - den_src;
        rem_nxt = q_bit ? rem_sub : rem_sh[DEN_W-1:0];
    end

    // Iteration state, start/abort handling and the done pulse.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            rem_q  <= '0;
            den_q  <= '0;
            nlo_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                rem_q  <= rem_nxt;
                nlo_q  <= {nlo_q[QUO_W-2:0], 1'b0};
                quo_q  <= {quo_q[QUO_W-2:0], q_bit};
                step_q <= step_q + StepW'(1);
                if (step_q == LastStep) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start_i) begin
                rem_q  <= rem_nxt;
                den_q  <= den_i;
                nlo_q  <= {num_i[QUO_W-2:0], 1'b0};
                quo_q  <= QUO_W'(q_bit);
                step_q <= StepW'(1);
                busy_q <= 1'b1;
            end
        end
    end

    // Busy spans the done cycle so a new start cannot overwrite the quotient before it is taken.
    assign busy_o = busy_q | done_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input and reports duty cycle in percent.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 pwm_in,
    output logic [DUTY_BITS-1:0] duty_cycle,
    output logic                 valid,
    output logic [CNT_BITS-1:0]  high_count,
    output logic [CNT_BITS-1:0]  period_count,
    output logic                 timeout
);

    localparam int unsigned NumW = CNT_BITS + DUTY_BITS;
    localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CntMax = '1;

    logic sync1_q, sync2_q, prev_q;

    state_e               state_q;
    logic [CNT_BITS-1:0]  pcnt_q, hcnt_q;
    logic [CNT_BITS-1:0]  cap_h_q, cap_p_q;
    logic                 stall_q;
    logic [DUTY_BITS-1:0] duty_q;
    logic                 valid_q;
    logic [CNT_BITS-1:0]  high_q, period_q;
    logic                 timeout_q;

    logic                 rise;
    logic                 counting;
    logic                 tmo_fire;
    logic                 div_start;
    logic                 div_busy;
    logic                 div_done;
    logic [DUTY_BITS-1:0] div_quo;
    logic [NumW-1:0]      div_num;

    // Two-flop synchronizer plus edge-detect history flop.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge detect, timeout detection and divider start qualification.
    always_comb begin
        rise      = sync2_q & ~prev_q;
        // After a timeout the period counter parks until the next rise, so it fires once per stall.
        counting  = ((state_q == StArm) && !stall_q) || (state_q == StMeasure);
        tmo_fire  = en && counting && !rise && (pcnt_q == CntMax);
        div_start = en && (state_q == StMeasure) && rise && !div_busy;
    end

    assign div_num = NumW'(hcnt_q) * NumW'(DUTY_SCALE);

    serial_divider #(
        .NUM_W (NumW),
        .DEN_W (CNT_BITS),
        .QUO_W (DUTY_BITS)
    ) u_div (
        .clk_i   (clk),
        .clr_i   (clr),
        .start_i (div_start),
        .abort_i (~en),
        .num_i   (div_num),
        .den_i   (pcnt_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    // Measurement FSM, counters and registered result outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            cap_h_q   <= '0;
            cap_p_q   <= '0;
            stall_q   <= 1'b0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            high_q    <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en) begin
                state_q <= StIdle;
                pcnt_q  <= '0;
                hcnt_q  <= '0;
                stall_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StArm;
                        pcnt_q  <= '0;
                        hcnt_q  <= '0;
                    end
                    StArm: begin
                        if (rise) begin
                            state_q <= StMeasure;
                            pcnt_q  <= CntOne;
                            hcnt_q  <= CntOne;
                            stall_q <= 1'b0;
                        end else if (!stall_q) begin
                            pcnt_q <= pcnt_q + CntOne;
                        end
                    end
                    StMeasure: begin
                        if (rise) begin
                            pcnt_q <= CntOne;
                            hcnt_q <= CntOne;
                            // A capture that collides with a running divide is dropped.
                            if (!div_busy) begin
                                cap_h_q <= hcnt_q;
                                cap_p_q <= pcnt_q;
                            end
                        end else begin
                            pcnt_q <= pcnt_q + CntOne;
                            if (sync2_q) begin
                                hcnt_q <= hcnt_q + CntOne;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase

                if (tmo_fire) begin
                    state_q   <= StArm;
                    pcnt_q    <= '0;
                    hcnt_q    <= '0;
                    stall_q   <= 1'b1;
                    duty_q    <= sync2_q ? DUTY_SCALE : '0;
                    valid_q   <= 1'b1;
                    timeout_q <= 1'b1;
                end

                if (div_done) begin
                    duty_q    <= div_quo;
                    high_q    <= cap_h_q;
                    period_q  <= cap_p_q;
                    valid_q   <= 1'b1;
                    timeout_q <= 1'b0;
                end
            end
        end
    end

    assign duty_cycle   = duty_q;
    assign valid        = valid_q;
    assign high_count   = high_q;
    assign period_count = period_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with CNT_BITS=8; valid pulses are logged with cycle stamps.
module tb_pwm_capture;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic          pwm_in;
    logic [6:0]    duty_cycle;
    logic          valid;
    logic [CW-1:0] high_count;
    logic [CW-1:0] period_count;
    logic          timeout;

    typedef struct {
        int duty;
        int hc;
        int pc;
        int to;
        int cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_bad = 0;

    pwm_capture #(
        .CNT_BITS (CW)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .en           (en),
        .pwm_in       (pwm_in),
        .duty_cycle   (duty_cycle),
        .valid        (valid),
        .high_count   (high_count),
        .period_count (period_count),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every valid pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            evq.push_back('{duty: int'(duty_cycle), hc: int'(high_count),
                            pc: int'(period_count), to: int'(timeout), cyc: cyc});
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input int duty, input int hc,
                            input int pc, input int to);
        if (idx < evq.size()) begin
            chk({tag, "_duty"}, evq[idx].duty, duty);
            chk({tag, "_hc"}, evq[idx].hc, hc);
            chk({tag, "_pc"}, evq[idx].pc, pc);
            chk({tag, "_to"}, evq[idx].to, to);
        end else begin
            chk({tag, "_present"}, evq.size(), idx + 1);
        end
    endtask

    task automatic check_cyc(input string tag, input int idx, input int exp);
        if (idx < evq.size()) chk(tag, evq[idx].cyc, exp);
        else chk({tag, "_present"}, evq.size(), idx + 1);
    endtask

    task automatic check_outs(input string tag, input int duty, input int hc, input int pc,
                              input int to);
        chk({tag, "_duty"}, int'(duty_cycle), duty);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_hc"}, int'(high_count), hc);
        chk({tag, "_pc"}, int'(period_count), pc);
        chk({tag, "_to"}, int'(timeout), to);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int hi, input int lo);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(lo);
    endtask

    initial begin
        int s;
        int n;

        clr    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        check_outs("reset", 0, 0, 0, 0);
        clr = 1'b0;
        en  = 1'b1;
        tick(5);

        // Steady 50/150: first rise arms, then one result per period.
        evq.delete();
        s = cyc;
        repeat (4) drive(50, 150);
        chk("steady_count", evq.size(), 3);
        check_ev("steady0", 0, 25, 50, 200, 0);
        check_ev("steady2", 2, 25, 50, 200, 0);
        check_cyc("steady0_cyc", 0, s + 210);
        check_cyc("steady2_cyc", 2, s + 610);

        // Clear while a divide is in flight.
        evq.delete();
        pwm_in = 1'b1;
        tick(6);
        clr = 1'b1;
        #1;
        check_outs("clr_mid", 0, 0, 0, 0);
        tick(2);
        clr    = 1'b0;
        pwm_in = 1'b0;
        tick(20);
        chk("clr_no_valid", evq.size(), 0);

        // Narrow high pulse truncates to zero.
        evq.delete();
        repeat (3) drive(1, 199);
        chk("narrow_count", evq.size(), 2);
        check_ev("narrow1", 1, 0, 1, 200, 0);

        // Narrow low pulse: 19900/200 truncates to 99.
        evq.delete();
        repeat (3) drive(199, 1);
        pwm_in = 1'b1;
        n = cyc;
        tick(20);
        chk("wide_count", evq.size(), 4);
        check_ev("wide0", 0, 0, 1, 200, 0);
        check_ev("wide1", 1, 99, 199, 200, 0);
        check_ev("wide3", 3, 99, 199, 200, 0);
        check_cyc("wide3_cyc", 3, n + 10);

        // Held high: one timeout result, counts unchanged.
        evq.delete();
        tick(300);
        chk("tmo_hi_count", evq.size(), 1);
        check_ev("tmo_hi", 0, 100, 199, 200, 1);
        check_cyc("tmo_hi_cyc", 0, n + 258);

        // Re-arm with a short pulse, then hold low.
        pwm_in = 1'b0;
        tick(10);
        evq.delete();
        pwm_in = 1'b1;
        n = cyc;
        tick(5);
        pwm_in = 1'b0;
        tick(300);
        chk("tmo_lo_count", evq.size(), 1);
        check_ev("tmo_lo", 0, 0, 199, 200, 1);
        check_cyc("tmo_lo_cyc", 0, n + 258);

        // Period 5: every other capture collides with the running divide.
        evq.delete();
        s = cyc;
        repeat (12) drive(2, 3);
        tick(20);
        chk("short_count", evq.size(), 6);
        check_ev("short0", 0, 40, 2, 5, 0);
        check_ev("short5", 5, 40, 2, 5, 0);
        check_cyc("short0_cyc", 0, s + 15);
        check_cyc("short5_cyc", 5, s + 65);

        // Enable dropped mid-divide: no result, outputs hold.
        en = 1'b0;
        tick(5);
        en = 1'b1;
        tick(5);
        evq.delete();
        repeat (2) drive(50, 150);
        chk("en_pre_count", evq.size(), 1);
        check_ev("en_pre", 0, 25, 50, 200, 0);
        evq.delete();
        pwm_in = 1'b1;
        tick(6);
        en = 1'b0;
        tick(44);
        pwm_in = 1'b0;
        tick(20);
        chk("en_drop_count", evq.size(), 0);
        check_outs("en_hold", 25, 50, 200, 0);

        // Re-enable: first result one full period after the arming rise.
        en = 1'b1;
        tick(5);
        evq.delete();
        s = cyc;
        repeat (2) drive(30, 70);
        tick(20);
        chk("reen_count", evq.size(), 1);
        check_ev("reen", 0, 30, 30, 100, 0);
        check_cyc("reen_cyc", 0, s + 110);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
